// File: rtl/io_bus_master.sv
// rtl/io_bus_master.sv - command-driven initiator for the single-cycle memory-mapped IO bus
// One command in flight: write, read, or poll (re-read until the masked compare matches or retries run out).
module io_bus_master #(
    parameter int DW       = 16,
    parameter int AW       = 12,
    parameter int RD_LAT   = 1,
    parameter int POLL_W   = 8,
    parameter int POLL_MAX = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [DW-1:0] cmd_mask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic          bus_we,
    input  logic [DW-1:0] bus_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RSP
    } state_t;

    localparam int                CW        = $clog2(RD_LAT + 2);
    localparam logic [CW-1:0]     LAST_CYC  = CW'(RD_LAT);
    localparam logic [POLL_W-1:0] RETRY_MAX = POLL_W'(POLL_MAX);
    localparam logic [1:0]        OP_WR     = 2'b00;
    localparam logic [1:0]        OP_RD     = 2'b01;
    localparam logic [1:0]        OP_POLL   = 2'b10;

    state_t              r_state,     w_state_nxt;
    logic                r_is_poll,   w_is_poll_nxt;
    logic [DW-1:0]       r_cmp,       w_cmp_nxt;
    logic [DW-1:0]       r_mask,      w_mask_nxt;
    logic [CW-1:0]       r_cnt,       w_cnt_nxt;
    logic [POLL_W-1:0]   r_retry,     w_retry_nxt;
    logic [DW-1:0]       r_rsp_data,  w_rsp_data_nxt;
    logic                r_rsp_err,   w_rsp_err_nxt;
    logic [AW-1:0]       r_bus_addr,  w_bus_addr_nxt;
    logic [DW-1:0]       r_bus_wdata, w_bus_wdata_nxt;
    logic                r_bus_we,    w_bus_we_nxt;

    logic w_match;
    logic w_last;

    assign w_match = ((bus_rdata ^ r_cmp) & r_mask) == '0;
    assign w_last  = (r_cnt == LAST_CYC);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_is_poll   <= 1'b0;
            r_cmp       <= '0;
            r_mask      <= '0;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_we    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_is_poll   <= w_is_poll_nxt;
            r_cmp       <= w_cmp_nxt;
            r_mask      <= w_mask_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_bus_we    <= w_bus_we_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_is_poll_nxt   = r_is_poll;
        w_cmp_nxt       = r_cmp;
        w_mask_nxt      = r_mask;
        w_cnt_nxt       = r_cnt;
        w_retry_nxt     = r_retry;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_err_nxt   = r_rsp_err;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wdata_nxt = r_bus_wdata;
        w_bus_we_nxt    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_is_poll_nxt = (cmd_op == OP_POLL);
                    w_cmp_nxt     = cmd_wdata;
                    w_mask_nxt    = cmd_mask;
                    w_cnt_nxt     = '0;
                    w_retry_nxt   = '0;
                    if (cmd_op == OP_WR) begin
                        w_bus_addr_nxt  = cmd_addr;
                        w_bus_wdata_nxt = cmd_wdata;
                        w_bus_we_nxt    = 1'b1;
                        w_state_nxt     = S_WR;
                    end else if (cmd_op == OP_RD || cmd_op == OP_POLL) begin
                        w_bus_addr_nxt = cmd_addr;
                        w_state_nxt    = S_RD;
                    end else begin
                        // Reserved op answers with an error and never touches the bus.
                        w_rsp_data_nxt = '0;
                        w_rsp_err_nxt  = 1'b1;
                        w_state_nxt    = S_RSP;
                    end
                end
            end
            S_WR: begin
                w_rsp_data_nxt = '0;
                w_rsp_err_nxt  = 1'b0;
                w_state_nxt    = S_RSP;
            end
            S_RD: begin
                if (!w_last) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end else if (!r_is_poll || w_match) begin
                    w_rsp_data_nxt = bus_rdata;
                    w_rsp_err_nxt  = 1'b0;
                    w_state_nxt    = S_RSP;
                end else if (r_retry == RETRY_MAX) begin
                    w_rsp_data_nxt = bus_rdata;
                    w_rsp_err_nxt  = 1'b1;
                    w_state_nxt    = S_RSP;
                end else begin
                    // Back-to-back retry window with the address still held.
                    w_retry_nxt = r_retry + POLL_W'(1);
                    w_cnt_nxt   = '0;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = (r_state == S_RSP);
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_we    = r_bus_we;

endmodule

// File: tb/tb_io_bus_master.sv
// tb/tb_io_bus_master.sv - bench for io_bus_master against a registered-dout GPIO peripheral model
// Responses are matched against a scoreboard queue; cycle-exact corners are checked inline.
module tb_io_bus_master;

    localparam int DW = 16;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [DW-1:0] cmd_mask = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_we;
    logic [DW-1:0] bus_rdata = '0;
    logic          busy;

    logic [DW-1:0] gpio_in = '0;
    logic [DW-1:0] mem [16];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mask;
        logic [DW-1:0] gpio;
        logic [DW-1:0] exp_data;
        logic          exp_err;
    } vec_t;

    rsp_t sb[$];
    rsp_t mon_e;
    vec_t tbl[9];

    io_bus_master #(
        .DW(DW), .AW(AW), .RD_LAT(1), .POLL_W(8), .POLL_MAX(3)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_rdata(bus_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Peripheral: address 0 reads the GPIO input, others a small register file; dout registered.
    always @(posedge clk) begin
        if (bus_we) mem[bus_addr[3:0]] <= bus_wdata;
        bus_rdata <= (bus_addr == '0) ? gpio_in : mem[bus_addr[3:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input logic [DW-1:0] d, input logic e);
        rsp_t t;
        t.data = d;
        t.err  = e;
        sb.push_back(t);
    endtask

    // Sampled after inputs settle in the low phase, before the next rising edge.
    always @(negedge clk) begin
        #2;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got data %h err %b with none expected", rsp_data, rsp_err);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
                check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] mk);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_mask  = mk;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("cmd_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic count_reads(output int rd, input bit raise_bit7);
        int n;
        rd = 0;
        n  = 0;
        while (n < 60) begin
            @(negedge clk);
            if (rsp_valid) break;
            if (busy && !bus_we) rd++;
            if (raise_bit7 && rd == 4) gpio_in = gpio_in | 16'h0080;
            n++;
        end
    endtask

    initial begin
        int rd;
        int n;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        tbl[0] = '{2'b00, 12'h005, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tbl[1] = '{2'b00, 12'h00A, 16'h1357, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tbl[2] = '{2'b01, 12'h005, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 1'b0};
        tbl[3] = '{2'b01, 12'h00A, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h1357, 1'b0};
        tbl[4] = '{2'b10, 12'h005, 16'hBE00, 16'hFF00, 16'h0000, 16'hBEEF, 1'b0};
        tbl[5] = '{2'b10, 12'h000, 16'hFFFF, 16'h0000, 16'h0F0F, 16'h0F0F, 1'b0};
        tbl[6] = '{2'b01, 12'h000, 16'h0000, 16'h0000, 16'h5A5A, 16'h5A5A, 1'b0};
        tbl[7] = '{2'b11, 12'h123, 16'h4444, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        tbl[8] = '{2'b10, 12'h00A, 16'h0000, 16'h0001, 16'h0000, 16'h1357, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        #1 rst = 1'b0;

        // Write: we only in cycle 1, response in cycle 2.
        expect_rsp(16'h0000, 1'b0);
        send(2'b00, 12'h001, 16'h1234, 16'h0000);
        @(negedge clk);
        check("wr_c1_we", 32'(bus_we), 32'd1);
        check("wr_c1_addr", 32'(bus_addr), 32'h001);
        check("wr_c1_wdata", 32'(bus_wdata), 32'h1234);
        check("wr_c1_ready", 32'(cmd_ready), 32'd0);
        check("wr_c1_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("wr_c2_we", 32'(bus_we), 32'd0);
        check("wr_c2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_c2_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("wr_c3_ready", 32'(cmd_ready), 32'd1);
        check("wr_c3_rsp_valid", 32'(rsp_valid), 32'd0);
        drain();

        // Read: response in cycle 3.
        gpio_in = 16'hA5C3;
        expect_rsp(16'hA5C3, 1'b0);
        send(2'b01, 12'h000, 16'h0000, 16'h0000);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            check("rd_we_low", 32'(bus_we), 32'd0);
            check("rd_rsp_not_yet", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        check("rd_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_c3_bus_we", 32'(bus_we), 32'd0);
        drain();

        // Poll that matches on the third window.
        gpio_in = 16'h1200;
        expect_rsp(16'h1280, 1'b0);
        send(2'b10, 12'h000, 16'h0080, 16'h0080);
        count_reads(rd, 1'b1);
        check("poll_read_cycles", rd, 6);
        drain();

        // Poll timeout: POLL_MAX=3 gives four windows.
        gpio_in = 16'h0001;
        expect_rsp(16'h0001, 1'b1);
        send(2'b10, 12'h000, 16'h0080, 16'h0080);
        count_reads(rd, 1'b0);
        check("poll_timeout_cycles", rd, 8);
        drain();

        // Response back-pressure with a queued command waiting.
        mem[5] = 16'hBEEF;
        rsp_ready = 1'b0;
        expect_rsp(16'hBEEF, 1'b0);
        send(2'b01, 12'h005, 16'h0000, 16'h0000);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_rsp_seen", 32'(rsp_valid), 32'd1);
        #1;
        expect_rsp(16'h0000, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_addr  = 12'h006;
        cmd_wdata = 16'h4321;
        cmd_mask  = 16'h0000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_data", 32'(rsp_data), 32'hBEEF);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_bus_we", 32'(bus_we), 32'd0);
            check("hold_bus_addr", 32'(bus_addr), 32'h005);
        end
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("hold_after_rsp_valid", 32'(rsp_valid), 32'd0);
        check("hold_after_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("hold_next_we", 32'(bus_we), 32'd1);
        check("hold_next_addr", 32'(bus_addr), 32'h006);
        drain();

        // Reset during the second read cycle aborts without a response.
        send(2'b01, 12'h00A, 16'h0000, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_busy_low", 32'(busy), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_data", 32'(rsp_data), 32'd0);
        check("abort_rsp_err", 32'(rsp_err), 32'd0);
        check("abort_bus_addr", 32'(bus_addr), 32'd0);
        check("abort_bus_wdata", 32'(bus_wdata), 32'd0);
        check("abort_bus_we", 32'(bus_we), 32'd0);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_rsp", 32'(rsp_valid), 32'd0);

        // Reserved op: immediate error response, bus untouched.
        expect_rsp(16'h0000, 1'b1);
        send(2'b11, 12'h7FF, 16'hFFFF, 16'h0000);
        @(negedge clk);
        check("rsv_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsv_bus_we", 32'(bus_we), 32'd0);
        check("rsv_bus_addr", 32'(bus_addr), 32'd0);
        drain();

        for (int i = 0; i < 9; i++) begin
            gpio_in = tbl[i].gpio;
            expect_rsp(tbl[i].exp_data, tbl[i].exp_err);
            send(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].mask);
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
